// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender between N_REQ FWFT byte sources.
// Latency: pop strobe in the cycle after a request is sampled in IDLE, tx_start one cycle later.
// Backpressure: waits in LAUNCH while tx_busy is high; watchdog aborts a frame whose tx_done never arrives.
module uart_tx_arbiter #(
    parameter  int N_REQ          = 2,
    parameter  int DATA_W         = 8,
    parameter  int GAP_CYCLES     = 16,
    parameter  int TIMEOUT_CYCLES = 200000,
    localparam int GID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_pop,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [GID_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GID_W-1:0] GID_LAST = GID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   last_grant_q, last_grant_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [N_REQ-1:0]   req_pop_q, req_pop_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;

    logic               pick_vld;
    logic [GID_W-1:0]   pick_idx;
    logic [GID_W-1:0]   cand;
    logic [DATA_W-1:0]  pick_dat;

    // Round-robin scan starting just after last_grant; walking backwards leaves the nearest valid index.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = GID_W'((int'(last_grant_q) + i) % N_REQ);
            if (req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Select the head byte of the chosen requester.
    always_comb begin
        pick_dat = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx == GID_W'(k)) begin
                pick_dat = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic of the grant/launch/wait/gap sequencer.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        gap_cnt_d     = gap_cnt_q;
        to_cnt_d      = to_cnt_q;
        req_pop_d     = '0;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        grant_id_d    = grant_id_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (en && pick_vld) begin
                    req_pop_d[pick_idx] = 1'b1;
                    tx_data_d           = pick_dat;
                    grant_id_d          = pick_idx;
                    last_grant_d        = pick_idx;
                    state_d             = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Sender may still be finishing a frame started elsewhere; watchdog not armed yet.
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    to_cnt_d   = '0;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // tx_done takes priority over a coincident watchdog expiry.
                if (tx_done) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= GID_LAST;
            gap_cnt_q     <= '0;
            to_cnt_q      <= '0;
            req_pop_q     <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            gap_cnt_q     <= gap_cnt_d;
            to_cnt_q      <= to_cnt_d;
            req_pop_q     <= req_pop_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_pop     = req_pop_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: FWFT FIFO and sender models, scoreboard of expected frames.
// Latency: checks pop-to-start of one cycle, gap length and watchdog distance.
// Backpressure: exercises tx_busy held at launch and a sender that never answers.
module tb_uart_tx_arbiter;

    localparam int N   = 2;
    localparam int DW  = 8;
    localparam int GAP = 16;
    localparam int TO  = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_pop;
    logic [DW-1:0] tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          tx_done = 1'b0;
    logic [0:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_pop(req_pop),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // FWFT FIFO models: the stimulus process owns the write side, this block owns the read side.
    logic [DW-1:0] fmem [N][64];
    int wr_ptr [N] = '{default: 0};
    int rd_ptr [N] = '{default: 0};
    int flush_tok = 0;
    int flush_done = 0;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++)
            if (req_pop[i] && rd_ptr[i] != wr_ptr[i]) rd_ptr[i]++;
        if (flush_tok != flush_done) begin
            for (int i = 0; i < N; i++) rd_ptr[i] = wr_ptr[i];
            flush_done = flush_tok;
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (rd_ptr[i] != wr_ptr[i]);
            req_data[i*DW +: DW] = fmem[i][rd_ptr[i] % 64];
        end
    end

    // Sender model: answers tx_start with tx_done after snd_dly cycles unless hung.
    logic snd_active = 1'b0;
    int   snd_cnt = 0;
    int   snd_dly = 4;
    logic hang = 1'b0;
    logic busy_force = 1'b0;
    assign tx_busy = busy_force | snd_active;

    always @(posedge clk) begin
        #2;
        tx_done = 1'b0;
        if (snd_active) begin
            if (snd_cnt <= 1) begin
                snd_active = 1'b0;
                tx_done = 1'b1;
            end else begin
                snd_cnt--;
            end
        end
        if (tx_start && !hang) begin
            snd_active = 1'b1;
            snd_cnt = snd_dly;
        end
    end

    // Pop strobe must never have more than one bit set.
    int pop_viol = 0;
    always @(negedge clk) if ($countones(req_pop) > 1) pop_viol++;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [0:0]    gid;
        logic [DW-1:0] dat;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0]    mask;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            gid;
        logic [DW-1:0] dat;
    } vec_t;
    vec_t tbl [9];

    int n;
    bit ok;
    int cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic push(input int r, input logic [DW-1:0] b);
        fmem[r][wr_ptr[r] % 64] = b;
        wr_ptr[r]++;
    endtask

    task automatic expect_tx(input int g, input logic [DW-1:0] d);
        exp_t e;
        e.gid = 1'(g);
        e.dat = d;
        exp_q.push_back(e);
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return req_pop != '0;
            1:       return tx_start;
            2:       return timeout_err;
            3:       return !busy;
            4:       return tx_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, output int cyc, output bit found);
        found = 1'b0;
        cyc = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (cond(which)) begin
                cyc = k;
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got unexpected frame %0h, want none", tag, tx_data);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_dat"}, 32'(tx_data), 32'(e.dat));
            chk({tag, "_gid"}, 32'(grant_id), 32'(e.gid));
        end
    endtask

    task automatic start_and_check(input string tag, input int budget);
        int c;
        bit f;
        wait_for(1, budget, c, f);
        chk({tag, "_start_wait"}, 32'(f), 32'd1);
        if (f) sb_pop(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{mask: 2'b01, d0: 8'h41, d1: 8'h00, gid: 0, dat: 8'h41};
        tbl[1] = '{mask: 2'b11, d0: 8'h10, d1: 8'h20, gid: 1, dat: 8'h20};
        tbl[2] = '{mask: 2'b11, d0: 8'h11, d1: 8'h21, gid: 0, dat: 8'h11};
        tbl[3] = '{mask: 2'b10, d0: 8'h00, d1: 8'h55, gid: 1, dat: 8'h55};
        tbl[4] = '{mask: 2'b01, d0: 8'hAA, d1: 8'h00, gid: 0, dat: 8'hAA};
        tbl[5] = '{mask: 2'b01, d0: 8'hBB, d1: 8'h00, gid: 0, dat: 8'hBB};
        tbl[6] = '{mask: 2'b11, d0: 8'h33, d1: 8'h44, gid: 1, dat: 8'h44};
        tbl[7] = '{mask: 2'b10, d0: 8'h00, d1: 8'h66, gid: 1, dat: 8'h66};
        tbl[8] = '{mask: 2'b11, d0: 8'h77, d1: 8'h88, gid: 0, dat: 8'h77};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_pop", 32'(req_pop), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_toerr", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;

        // Single frame from requester 0: pop, one-cycle launch, gap length.
        @(negedge clk);
        en = 1'b1;
        push(0, 8'h41);
        expect_tx(0, 8'h41);
        wait_for(0, 10, n, ok);
        chk("s1_pop_wait", 32'(ok), 32'd1);
        chk("s1_pop", 32'(req_pop), 32'd1);
        @(negedge clk);
        chk("s1_launch_lat", 32'(tx_start), 32'd1);
        if (tx_start) sb_pop("s1");
        @(negedge clk);
        chk("s1_start_pulse", 32'(tx_start), 32'd0);
        wait_for(4, 50, n, ok);
        chk("s1_done_wait", 32'(ok), 32'd1);
        wait_for(3, 40, n, ok);
        chk("s1_gap_len", 32'(n), 32'(GAP + 1));

        // Table of single grants from a fresh reset (first scan starts at requester 0).
        do_reset();
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            if (tbl[v].mask[0]) push(0, tbl[v].d0);
            if (tbl[v].mask[1]) push(1, tbl[v].d1);
            expect_tx(tbl[v].gid, tbl[v].dat);
            wait_for(0, 10, n, ok);
            chk($sformatf("tbl%0d_pop", v), 32'(req_pop), 32'(1 << tbl[v].gid));
            @(negedge clk);
            chk($sformatf("tbl%0d_lat", v), 32'(tx_start), 32'd1);
            if (tx_start) sb_pop($sformatf("tbl%0d", v));
            flush_tok++;
            wait_for(3, 100, n, ok);
            chk($sformatf("tbl%0d_idle", v), 32'(ok), 32'd1);
        end

        // Both requesters continuously valid: strict alternation.
        do_reset();
        @(negedge clk);
        push(0, 8'h10); push(0, 8'h11);
        push(1, 8'h20); push(1, 8'h21);
        expect_tx(0, 8'h10); expect_tx(1, 8'h20);
        expect_tx(0, 8'h11); expect_tx(1, 8'h21);
        for (int f = 0; f < 4; f++) start_and_check($sformatf("rr%0d", f), 200);
        wait_for(3, 100, n, ok);
        chk("rr_idle", 32'(ok), 32'd1);

        // Only requester 1 valid after reset, then requester 0 joins.
        do_reset();
        @(negedge clk);
        push(1, 8'h55);
        expect_tx(1, 8'h55);
        start_and_check("skip_r1", 20);
        push(0, 8'h5A);
        expect_tx(0, 8'h5A);
        start_and_check("skip_r0", 200);
        wait_for(3, 100, n, ok);
        chk("skip_idle", 32'(ok), 32'd1);

        // Sender busy at launch, then a hung sender trips the watchdog.
        @(negedge clk);
        busy_force = 1'b1;
        hang = 1'b1;
        push(0, 8'h77);
        expect_tx(0, 8'h77);
        wait_for(0, 10, n, ok);
        chk("hold_pop", 32'(ok), 32'd1);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_start || timeout_err) cnt++;
        end
        chk("hold_no_start", 32'(cnt), 32'd0);
        busy_force = 1'b0;
        @(negedge clk);
        chk("hold_release_start", 32'(tx_start), 32'd1);
        if (tx_start) sb_pop("hold");
        wait_for(2, 100, n, ok);
        chk("to_dist", 32'(n), 32'(TO));
        chk("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("to_pulse", 32'(timeout_err), 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_start || req_pop != '0) cnt++;
        end
        chk("to_no_retry", 32'(cnt), 32'd0);
        hang = 1'b0;

        // Enable gating in IDLE, and en dropped mid-frame.
        en = 1'b0;
        push(0, 8'h99);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (req_pop != '0) cnt++;
        end
        chk("en_off_pop", 32'(cnt), 32'd0);
        en = 1'b1;
        expect_tx(0, 8'h99);
        @(negedge clk);
        chk("en_on_pop", 32'(req_pop), 32'd1);
        start_and_check("en1", 10);
        en = 1'b0;
        push(0, 8'h9B);
        wait_for(4, 50, n, ok);
        chk("en_mid_done", 32'(ok), 32'd1);
        wait_for(3, 40, n, ok);
        chk("en_mid_gap", 32'(n), 32'(GAP + 1));
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (req_pop != '0) cnt++;
        end
        chk("en_mid_no_grant", 32'(cnt), 32'd0);
        en = 1'b1;
        expect_tx(0, 8'h9B);
        start_and_check("en2", 20);
        wait_for(3, 100, n, ok);
        chk("en2_idle", 32'(ok), 32'd1);

        // Reset during WAIT_DONE, then fairness restarts at requester 0.
        snd_dly = 30;
        @(negedge clk);
        push(1, 8'hC3);
        expect_tx(1, 8'hC3);
        start_and_check("mrst", 20);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_pop", 32'(req_pop), 32'd0);
        chk("mrst_start", 32'(tx_start), 32'd0);
        chk("mrst_data", 32'(tx_data), 32'd0);
        chk("mrst_gid", 32'(grant_id), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_toerr", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        snd_dly = 4;
        push(0, 8'hD0);
        push(1, 8'hD1);
        expect_tx(0, 8'hD0);
        expect_tx(1, 8'hD1);
        start_and_check("post0", 200);
        start_and_check("post1", 200);
        wait_for(3, 100, n, ok);
        chk("post_idle", 32'(ok), 32'd1);

        chk("pop_onehot", 32'(pop_viol), 32'd0);
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART sender between N_REQ byte sources, e.g. the button-driven sender FIFO and a parser echo/loopback FIFO.
- Each source presents a first-word-fall-through FIFO output. The block pops one byte at a time using round-robin order and sequences the sender's start/busy/done handshake.
- Enforces a minimum inter-frame gap and a watchdog timeout so a hung sender cannot stall the link.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DATA_W, 8, byte width
- GAP_CYCLES, 16, idle clocks after each txDone before the next grant (0 allowed)
- TIMEOUT_CYCLES, 200000, max clocks from tx_start to tx_done before abort

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  arbitration enable; sampled only in IDLE
- req_valid  in  N_REQ  requester i has a byte (FIFO not empty)
- req_data  in  N_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W], FWFT
- req_pop  out  N_REQ  one-hot 1-cycle pop strobe to requester i's FIFO
- tx_data  out  DATA_W  registered byte to sender
- tx_start  out  1  1-cycle start pulse to sender
- tx_busy  in  1  sender busy
- tx_done  in  1  sender 1-cycle done pulse
- grant_id  out  max(1,clog2(N_REQ))  index of current/last granted requester
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  1-cycle pulse on watchdog abort

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE; tx_start=0, tx_data=0, req_pop=0, grant_id=0, busy=0, timeout_err=0
  - last_grant=N_REQ-1, so the first grant goes to requester 0
  - gap and timeout counters =0
- All outputs are registered.
- IDLE:
  - Condition: en=1 and any req_valid.
  - Pick the first valid index scanning last_grant+1, last_grant+2, … modulo N_REQ.
  - In the same cycle: assert req_pop[g] for exactly 1 cycle, capture req_data[g] into tx_data, set grant_id=g and last_grant=g, then go to LAUNCH.
  - With en=0 or no valid request: stay in IDLE, no pop.
- LAUNCH:
  - If tx_busy=0: pulse tx_start for 1 cycle, clear the timeout counter, go to WAIT_DONE.
  - If tx_busy=1 (sender still finishing a foreign frame): hold with tx_start=0 until tx_busy=0. The timeout counter is not running here.
- WAIT_DONE:
  - The timeout counter increments every cycle.
  - On tx_done=1: go to GAP (or straight to IDLE if GAP_CYCLES=0).
  - If the counter reaches TIMEOUT_CYCLES-1 without tx_done: pulse timeout_err, drop the byte (no retry), go to IDLE.
  - If tx_done and timeout coincide, tx_done wins: no error.
- GAP: count GAP_CYCLES clocks, then go to IDLE. tx_done pulses arriving here are ignored.
- Latency:
  - Request seen in IDLE (cycle 0): pop at cycle 0, tx_start at cycle 1 when the sender is idle.
  - Next grant no earlier than GAP_CYCLES+1 cycles after tx_done.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0.
  - A requester that drops req_valid is skipped without losing its turn order.
- Other rules:
  - At most one req_pop bit is high in any cycle; req_pop is never asserted outside IDLE.
  - tx_data is stable from LAUNCH until the next IDLE grant.
  - en deasserted mid-frame does not abort; the current frame and its gap complete.
  - Reset mid-frame returns to IDLE immediately. The popped byte is lost and tx_start is forced low.

Test Plan:
- Requester 0 valid with 0x41, sender idle → req_pop=01 at cycle 0; tx_data=0x41 and tx_start pulse at cycle 1. After tx_done, GAP_CYCLES=16 idle clocks, busy=0 afterwards.
- Both valid continuously: r0 bytes 0x10,0x11 and r1 bytes 0x20,0x21 → tx order 0x10,0x20,0x11,0x21; grant_id sequence 0,1,0,1.
- Only r1 valid with 0x55, then r0 becomes valid → first grant r1 (last_grant reset=1 makes scan start at r0, which is invalid), next grant r0.
- tx_busy held high for 30 cycles at LAUNCH → tx_start delayed until tx_busy falls, no timeout_err. Then with TIMEOUT_CYCLES=50 and tx_done never arriving → timeout_err pulse exactly 50 cycles after tx_start, state IDLE, no retry of the byte.
- en=0 with r0 valid → no pop for 100 cycles. en=1 → pop next cycle. Deassert en during WAIT_DONE → frame and gap complete, no new grant.
- Assert rst_n low during WAIT_DONE → next edge shows all outputs at reset values. After release, the first grant goes to r0.
